// File: rtl/line_steering_pwm_pkg.sv
// Purpose: shared types, constants and helpers for the line-steering PWM block.
// Contents: track_state encoding, PWM period, error offset, history depth,
//           position-to-error conversion and duty saturation.
package line_steering_pwm_pkg;

    localparam int unsigned POS_W      = 4;
    localparam int unsigned EDGE_W     = 16;
    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned ERR_W      = 6;
    localparam int unsigned SUM_W      = 7;
    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned AVG_SH     = $clog2(HIST_DEPTH);
    localparam int unsigned PWM_PERIOD = 255;
    localparam int unsigned ERR_OFFSET = 15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_COAST  = 2'd2;
    localparam logic [1:0] ST_SEARCH = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_TRACK  = ST_TRACK,
        S_COAST  = ST_COAST,
        S_SEARCH = ST_SEARCH
    } track_state_e;

    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    // Bin index to signed steering error: 0 -> -15, 15 -> +15.
    function automatic err_t pos_to_err(input logic [POS_W-1:0] pos);
        return $signed({1'b0, pos, 1'b0}) - err_t'(ERR_OFFSET);
    endfunction

    // Clamp a signed duty candidate into the 8-bit range.
    function automatic logic [DUTY_W-1:0] sat_duty(input int v);
        if (v < 0) begin
            return '0;
        end else if (v > int'(2**DUTY_W - 1)) begin
            return '1;
        end else begin
            return DUTY_W'(v);
        end
    endfunction

endpackage

// File: rtl/line_steering_pwm_pwm_channel.sv
// Purpose: one PWM channel with glitch-free duty update at period wrap.
// Ports: pixel_clock, reset_n (sync, active-low), tick (advance counter),
//        duty (requested duty), pwm (registered PWM output).
module pwm_channel
    import line_steering_pwm_pkg::*;
(
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] shadow_q, shadow_d;

    // Counter runs 0..PWM_PERIOD-1; shadow duty only reloads on the wrap.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (tick) begin
            if (cnt_q == DUTY_W'(PWM_PERIOD - 1)) begin
                cnt_d    = '0;
                shadow_d = duty;
            end else begin
                cnt_d = cnt_q + DUTY_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            pwm      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pwm      <= (cnt_d < shadow_d);
        end
    end

endmodule

// File: rtl/line_steering_pwm.sv
// Purpose: per-frame steering controller: captures line position at vsync
//          fall, filters error over four frames, runs IDLE/TRACK/COAST/SEARCH
//          and drives differential motor PWM.
// Ports: pixel_clock, reset_n (sync, active-low), vsync, line_position,
//        edge_max, enable in; pwm_left/right, duty_left/right, track_state,
//        frame_strobe out (all registered).
module line_steering_pwm
    import line_steering_pwm_pkg::*;
#(
    parameter int          BASE_DUTY   = 128,
    parameter int          GAIN        = 6,
    parameter int unsigned MIN_EDGES   = 64,
    parameter int unsigned LOST_FRAMES = 8,
    parameter int unsigned SEARCH_DUTY = 96,
    parameter int unsigned PWM_DIV     = 4
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic [POS_W-1:0]  line_position,
    input  logic [EDGE_W-1:0] edge_max,
    input  logic              enable,
    output logic              pwm_left,
    output logic              pwm_right,
    output logic [DUTY_W-1:0] duty_left,
    output logic [DUTY_W-1:0] duty_right,
    output logic [1:0]        track_state,
    output logic              frame_strobe
);

    localparam int unsigned LC_W  = $clog2(LOST_FRAMES + 1);
    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic               vsync_q, pend_q, valid_q, commit_q;
    logic [POS_W-1:0]   pos_q;
    track_state_e       state_q;
    err_t               hist_q [HIST_DEPTH];
    logic [LC_W-1:0]    lost_q;
    logic [DUTY_W-1:0]  ldut_q, rdut_q;
    logic [PRE_W-1:0]   pre_q;

    logic               fall_c, tick_c, lost_hit_c;
    logic [LC_W:0]      lost_inc_c;
    err_t               err_c;
    err_t               hist_sh_c [HIST_DEPTH];
    sum_t               sum_sh_c, sum_hold_c, avg_sh_c, avg_hold_c, avg_fill_c;
    logic [DUTY_W-1:0]  dl_sh_c, dr_sh_c, dl_fill_c, dr_fill_c, dl_srch_c, dr_srch_c;

    function automatic logic [DUTY_W-1:0] steer_duty(input sum_t avg, input logic left);
        int steer;
        steer = int'(avg) * GAIN;
        return left ? sat_duty(BASE_DUTY + steer) : sat_duty(BASE_DUTY - steer);
    endfunction

    assign fall_c = vsync_q & ~vsync & enable;

    // Error, shifted/held history averages and the duty candidates they imply.
    always_comb begin
        err_c        = pos_to_err(pos_q);
        hist_sh_c[0] = err_c;
        for (int i = 1; i < int'(HIST_DEPTH); i++) begin
            hist_sh_c[i] = hist_q[i-1];
        end
        sum_sh_c   = '0;
        sum_hold_c = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            sum_sh_c   = sum_sh_c + SUM_W'(hist_sh_c[i]);
            sum_hold_c = sum_hold_c + SUM_W'(hist_q[i]);
        end
        avg_sh_c   = sum_sh_c >>> AVG_SH;
        avg_hold_c = sum_hold_c >>> AVG_SH;
        avg_fill_c = SUM_W'(err_c);
        dl_sh_c    = steer_duty(avg_sh_c, 1'b1);
        dr_sh_c    = steer_duty(avg_sh_c, 1'b0);
        dl_fill_c  = steer_duty(avg_fill_c, 1'b1);
        dr_fill_c  = steer_duty(avg_fill_c, 1'b0);
        // SEARCH spins toward the side the line was last seen on.
        dl_srch_c  = avg_hold_c[SUM_W-1] ? '0 : DUTY_W'(SEARCH_DUTY);
        dr_srch_c  = avg_hold_c[SUM_W-1] ? DUTY_W'(SEARCH_DUTY) : '0;
        lost_inc_c = {1'b0, lost_q} + (LC_W+1)'(1);
        lost_hit_c = lost_inc_c >= (LC_W+1)'(LOST_FRAMES);
    end

    // Capture at T, state update at T+1, outputs committed at T+2.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            vsync_q      <= 1'b0;
            pend_q       <= 1'b0;
            valid_q      <= 1'b0;
            commit_q     <= 1'b0;
            pos_q        <= '0;
            state_q      <= S_IDLE;
            for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
            lost_q       <= '0;
            ldut_q       <= '0;
            rdut_q       <= '0;
            duty_left    <= '0;
            duty_right   <= '0;
            track_state  <= ST_IDLE;
            frame_strobe <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            pend_q       <= fall_c;
            commit_q     <= 1'b0;
            duty_left    <= ldut_q;
            duty_right   <= rdut_q;
            track_state  <= state_q;
            frame_strobe <= commit_q;
            if (fall_c) begin
                pos_q   <= line_position;
                valid_q <= (edge_max >= EDGE_W'(MIN_EDGES));
            end
            if (!enable) begin
                pend_q       <= 1'b0;
                state_q      <= S_IDLE;
                for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
                lost_q       <= '0;
                ldut_q       <= '0;
                rdut_q       <= '0;
                duty_left    <= '0;
                duty_right   <= '0;
                track_state  <= ST_IDLE;
                frame_strobe <= 1'b0;
            end else if (pend_q) begin
                commit_q <= 1'b1;
                if (valid_q) begin
                    state_q <= S_TRACK;
                    lost_q  <= '0;
                    if (state_q == S_TRACK || state_q == S_COAST) begin
                        hist_q <= hist_sh_c;
                        ldut_q <= dl_sh_c;
                        rdut_q <= dr_sh_c;
                    end else begin
                        for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= err_c;
                        ldut_q <= dl_fill_c;
                        rdut_q <= dr_fill_c;
                    end
                end else begin
                    case (state_q)
                        S_TRACK, S_COAST: begin
                            lost_q <= lost_inc_c[LC_W-1:0];
                            if (lost_hit_c) begin
                                state_q <= S_SEARCH;
                                ldut_q  <= dl_srch_c;
                                rdut_q  <= dr_srch_c;
                            end else begin
                                state_q <= S_COAST;
                            end
                        end
                        S_SEARCH: begin
                            ldut_q <= dl_srch_c;
                            rdut_q <= dr_srch_c;
                        end
                        default: begin
                            ldut_q <= '0;
                            rdut_q <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Shared PWM prescaler.
    assign tick_c = (pre_q == PRE_W'(PWM_DIV - 1));

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
        end
    end

    pwm_channel u_pwm_left (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .tick        (tick_c),
        .duty        (duty_left),
        .pwm         (pwm_left)
    );

    pwm_channel u_pwm_right (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .tick        (tick_c),
        .duty        (duty_right),
        .pwm         (pwm_right)
    );

endmodule
